// File: rtl/radiant_trigger_event_capture.sv
// Trigger event capture: timestamps and numbers each accepted trigger rise, applies holdoff, queues records in a FWFT FIFO.
// Define RADIANT_TRIG_PATTERN_EN to add the GATHER window and the 24-bit channel pattern capture.
module radiant_trigger_event_capture #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic        trig_clk_i,
    input  logic        rst_n_i,
    input  logic        trigger_i,
    input  logic [23:0] trig_i,
    input  logic        en_i,
    input  logic [3:0]  gather_i,
    input  logic [15:0] holdoff_i,
    output logic        evt_valid_o,
    input  logic        evt_ready_i,
    output logic [31:0] evt_time_o,
    output logic [15:0] evt_num_o,
    output logic [23:0] evt_pattern_o,
    output logic [15:0] dropped_o,
    output logic        busy_o
);

    localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
    localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned TS_W  = 32;
    localparam int unsigned NUM_W = 16;
    localparam int unsigned HC_W  = 16;

    typedef enum logic [1:0] {IDLE, GATHER, PUSH, HOLDOFF} state_e;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [NUM_W-1:0] num;
`ifdef RADIANT_TRIG_PATTERN_EN
        logic [23:0]      pattern;
`endif
    } rec_t;

    state_e             state_q, state_d;
    logic [TS_W-1:0]    ts_q;
    logic [TS_W-1:0]    time_q, time_d;
    logic [NUM_W-1:0]   num_q;
    logic [HC_W-1:0]    hcnt_q, hcnt_d;
    logic [15:0]        dropped_q;
    logic               trigger_q;
    logic               busy_q;
    logic               rise_c, push_c, full_c, wr_c, drop_c, pop_c;
`ifdef RADIANT_TRIG_PATTERN_EN
    logic [23:0]        pattern_q, pattern_d;
    logic [3:0]         gcnt_q, gcnt_d;
`else
    logic               unused_c;
    assign unused_c = ^{trig_i, gather_i};
`endif

    rec_t               mem_q [DEPTH];
    rec_t               wr_rec_c, head_c;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    assign rise_c = trigger_i & ~trigger_q;

    // Event sequencing: accept, optional pattern window, push, deadtime
    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        hcnt_d    = hcnt_q;
        push_c    = 1'b0;
`ifdef RADIANT_TRIG_PATTERN_EN
        pattern_d = pattern_q;
        gcnt_d    = gcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise_c && en_i) begin
                    time_d = ts_q;
`ifdef RADIANT_TRIG_PATTERN_EN
                    pattern_d = trig_i;
                    gcnt_d    = gather_i;
                    state_d   = (gather_i != 4'd0) ? GATHER : PUSH;
`else
                    state_d   = PUSH;
`endif
                end
            end
`ifdef RADIANT_TRIG_PATTERN_EN
            GATHER: begin
                pattern_d = pattern_q | trig_i;
                gcnt_d    = gcnt_q - 4'd1;
                if (gcnt_q == 4'd1) state_d = PUSH;
            end
`endif
            PUSH: begin
                push_c  = 1'b1;
                hcnt_d  = holdoff_i;
                state_d = (holdoff_i != 16'd0) ? HOLDOFF : IDLE;
            end
            HOLDOFF: begin
                hcnt_d = hcnt_q - HC_W'(1);
                if (hcnt_q == HC_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge trig_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            ts_q      <= '0;
            time_q    <= '0;
            num_q     <= '0;
            hcnt_q    <= '0;
            dropped_q <= '0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef RADIANT_TRIG_PATTERN_EN
            pattern_q <= '0;
            gcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_q + TS_W'(1);
            time_q    <= time_d;
            hcnt_q    <= hcnt_d;
            trigger_q <= trigger_i;
            busy_q    <= (state_d != IDLE);
`ifdef RADIANT_TRIG_PATTERN_EN
            pattern_q <= pattern_d;
            gcnt_q    <= gcnt_d;
`endif
            if (push_c) num_q <= num_q + NUM_W'(1);
            if (drop_c && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
        end
    end

    // Full is judged on pre-cycle occupancy, so push-while-full drops even when a pop happens
    assign full_c = (count_q == CNT_W'(DEPTH));
    assign pop_c  = evt_valid_o && evt_ready_i;
    assign wr_c   = push_c && !full_c;
    assign drop_c = push_c && full_c;

    always_comb begin
        wr_rec_c     = '0;
        wr_rec_c.ts  = time_q;
        wr_rec_c.num = num_q;
`ifdef RADIANT_TRIG_PATTERN_EN
        wr_rec_c.pattern = pattern_q;
`endif
    end

    always_ff @(posedge trig_clk_i) begin
        if (wr_c) mem_q[wr_ptr_q] <= wr_rec_c;
    end

    always_ff @(posedge trig_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_c      = mem_q[rd_ptr_q];
    assign evt_valid_o = (count_q != '0);
    assign dropped_o   = dropped_q;
    assign busy_o      = busy_q;

    // Head fields are forced to zero while empty so reset clears every output
    always_comb begin
        evt_time_o    = '0;
        evt_num_o     = '0;
        evt_pattern_o = '0;
        if (evt_valid_o) begin
            evt_time_o = head_c.ts;
            evt_num_o  = head_c.num;
`ifdef RADIANT_TRIG_PATTERN_EN
            evt_pattern_o = head_c.pattern;
`endif
        end
    end

endmodule

// File: doc/radiant_trigger_event_capture.md
# radiant_trigger_event_capture

Consumes the coincidence trigger output and the 24 per-channel discriminator inputs that feed it, all on the trigger clock domain. On each accepted trigger rising edge it records a 32-bit timestamp, a 16-bit event number and an OR-accumulated 24-bit channel pattern, then enforces a programmable holdoff. Completed records are queued in a small first-word-fall-through FIFO and handed to readout through a valid/ready handshake. Triggers lost because the FIFO is full are counted.

## Interface
- FIFO_DEPTH_LOG2, 2, log2 of the event FIFO depth (default depth 4 records).
- trig_clk_i  in  1  trigger clock; the only clock in the block.
- rst_n_i  in  1  asynchronous, active-low reset.
- trigger_i  in  1  coincidence trigger level; only its rising edge matters.
- trig_i  in  24  per-channel discriminator inputs, sampled for the pattern.
- en_i  in  1  capture enable; sampled only in IDLE.
- gather_i  in  4  pattern accumulation window, in cycles after the edge.
- holdoff_i  in  16  deadtime, in cycles after PUSH.
- evt_valid_o  out  1  the FIFO head holds a record.
- evt_ready_i  in  1  the consumer accepts the head record.
- evt_time_o  out  32  timestamp of the head record.
- evt_num_o  out  16  event number of the head record.
- evt_pattern_o  out  24  channel pattern of the head record.
- dropped_o  out  16  count of FIFO-full drops; saturates at 16'hFFFF.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- Timestamp counter: 32-bit, free-running, increments every cycle, wraps from FFFFFFFF to 0.
- Edge detect: trigger_q is trigger_i registered. rise = trigger_i & ~trigger_q.
- States: IDLE, GATHER, PUSH, HOLDOFF.
- IDLE, when rise && en_i:
  - latch the timestamp value at this edge;
  - set pattern to trig_i;
  - load gcnt with gather_i;
  - go to GATHER if gather_i != 0, otherwise go to PUSH.
- IDLE, otherwise: stay in IDLE.
- GATHER:
  - pattern |= trig_i every cycle;
  - gcnt decrements every cycle;
  - leave for PUSH after the cycle in which gcnt == 1.
- PUSH (exactly 1 cycle):
  - If the FIFO is not full, write {time, evtnum, pattern}.
  - If the FIFO is full, discard the record and increment dropped_o, saturating.
  - Increment evtnum (16-bit, wrapping) in both cases, so gaps in evt_num_o reveal drops.
  - Go to HOLDOFF with hcnt = holdoff_i, or to IDLE if holdoff_i == 0.
- HOLDOFF: hcnt decrements every cycle; leave for IDLE after the cycle in which hcnt == 1.
- Rising edges outside IDLE are ignored. They are not counted as drops.
- en_i and gather_i are sampled only on the IDLE accept cycle. holdoff_i is sampled only in PUSH. Changing them mid-event does not affect the event in progress.
- FIFO behaviour:
  - depth 2^FIFO_DEPTH_LOG2, first-word-fall-through;
  - evt_valid_o = !empty;
  - pop when evt_valid_o && evt_ready_i;
  - full is evaluated on the occupancy before the cycle, so a push and a pop in the same cycle while full rejects the push (counted as a drop) and still performs the pop.
- evt_*_o hold the head record and are stable while evt_valid_o && !evt_ready_i.
- Reset (rst_n_i low, asynchronous):
  - state to IDLE; all counters, the pattern and trigger_q to 0;
  - FIFO emptied;
  - every output 0.
  - Reset mid-event discards the event in progress.

## Timing
- Rise sampled at edge N, meaning trigger_i is low at N-1 and high at N. Timestamp = counter value at edge N.
- GATHER occupies cycles N+1 … N+G, where G = gather_i. PUSH is at N+G+1.
- A record written in PUSH raises evt_valid_o at N+G+2 if the FIFO was empty.
- HOLDOFF occupies N+G+2 … N+G+1+H, where H = holdoff_i. IDLE is at N+G+2+H.
- The earliest next accepted rise is sampled at edge N+G+2+H. Minimum event spacing is G+H+2 cycles.
- Pop: the head advances at the edge where valid && ready. The next record is presented in the following cycle.
- busy_o is high from N+1 through the last HOLDOFF cycle.

## Configuration
- RADIANT_TRIG_PATTERN_EN defined: pattern capture and the GATHER state are implemented as described above.
- RADIANT_TRIG_PATTERN_EN undefined:
  - the GATHER state, the pattern register and the FIFO pattern storage are removed;
  - IDLE goes directly to PUSH, so PUSH is at N+1;
  - evt_pattern_o is tied to 0; trig_i and gather_i are unused.

## Test plan
- gather_i=3, holdoff_i=10, trig_i bit 0 set at the edge, bit 5 pulsed at N+2, rise at N where the counter reads 100 → one record with time=100, num=0, pattern=24'h000021; evt_valid_o rises at N+5; busy_o falls at N+15.
- Second rise at N+14 with the same settings → ignored, num unchanged. A rise at N+15 → accepted as num=1.
- evt_ready_i held 0, FIFO_DEPTH_LOG2=2, 6 spaced triggers → 4 records queued, dropped_o=2. Draining yields num 0,1,2,3. The next accepted trigger gets num=6.
- FIFO full and evt_ready_i=1 in the PUSH cycle → the pop occurs, the push is rejected, dropped_o increments, and occupancy becomes 3.
- en_i=0 → rises produce no records and busy_o stays 0. Deassert rst_n_i mid-GATHER → all outputs return to 0 immediately, with no record.
- RADIANT_TRIG_PATTERN_EN undefined, holdoff_i=0, rise at N → evt_valid_o at N+2, pattern=0, next rise accepted at N+2.
